// File: rtl/ppwm_pkg.sv
// -----------------------------------------------------------------------------
// ppwm_pkg
// Shared types and constants for the PWM program path.
//   - Default instruction / program-counter widths used by the program store.
//   - command_e    : opcode field of an instruction word (CMD_CTRL = 3'b000).
//   - INSTR_NOP    : all-zero word, which decodes as a CMD_CTRL no-op.
//   - prog_state_e : program store state (StEmpty, StLoad, StRun).
// -----------------------------------------------------------------------------
package ppwm_pkg;

    localparam int PPWM_INSTR_WIDTH = 7;
    localparam int PPWM_PC_WIDTH    = 4;

    typedef enum logic [2:0] {
        CMD_CTRL = 3'b000
    } command_e;

    // The all-zero word carries CMD_CTRL with a zero argument, i.e. a NOP.
    localparam logic [PPWM_INSTR_WIDTH-1:0] INSTR_NOP = '0;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StLoad  = 2'd1,
        StRun   = 2'd2
    } prog_state_e;

    // Full-program word count for a given address width (2**pc_width).
    function automatic int prog_depth(input int pc_width);
        return 1 << pc_width;
    endfunction

endpackage : ppwm_pkg

// File: rtl/ppwm_prog_regfile.sv
// -----------------------------------------------------------------------------
// ppwm_prog_regfile
// 2**PC_WIDTH x INSTR_WIDTH flop array holding the PWM program.
//
// Optional feature (macro PPWM_PROG_MEM_READBACK_EN): adds a registered
// readback port with one cycle of latency.
//
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset, all words -> INSTR_NOP
//   clr      : synchronous clear of every word to INSTR_NOP (wins over write)
//   we       : write enable
//   waddr    : write address
//   wdata    : write data (stored unmodified)
//   raddr    : asynchronous read address
//   rdata    : word at raddr, zero latency
//   rd_addr  : readback address              (READBACK_EN only)
//   rd_data  : registered word at rd_addr    (READBACK_EN only)
// -----------------------------------------------------------------------------
module ppwm_prog_regfile
    import ppwm_pkg::*;
#(
    parameter int INSTR_WIDTH = PPWM_INSTR_WIDTH,
    parameter int PC_WIDTH    = PPWM_PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [PC_WIDTH-1:0]    waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [PC_WIDTH-1:0]    raddr,
    output logic [INSTR_WIDTH-1:0] rdata
`ifdef PPWM_PROG_MEM_READBACK_EN
    ,
    input  logic [PC_WIDTH-1:0]    rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data
`endif
);

    localparam int DEPTH = prog_depth(PC_WIDTH);
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(INSTR_NOP);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];

    // NOTE: this array is deliberately reset: the execution stage must see NOPs,
    // never X, for any word a short program did not write. It therefore maps to
    // flops rather than a RAM macro, which is acceptable at this depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOP_WORD;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read so the instruction lines up with the PC in-cycle.
    assign rdata = mem[raddr];

`ifdef PPWM_PROG_MEM_READBACK_EN
    // Samples the array before this edge's write lands, so a same-cycle write
    // to rd_addr returns the previous word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule : ppwm_prog_regfile

// File: rtl/ppwm_prog_mem.sv
// -----------------------------------------------------------------------------
// ppwm_prog_mem
// Program store directly upstream of the PWM execution stage. A program is
// streamed in over a valid/ready interface, then served combinationally to the
// execution stage by its program counter. run_o gates that stage; outside the
// running state the store presents INSTR_NOP.
//
// Optional feature (macro PPWM_PROG_MEM_READBACK_EN): registered readback port
// rd_addr_i / rd_data_o, valid in every state.
//
// Ports:
//   clk          : clock
//   rst          : asynchronous active-high reset
//   load_en_i    : level, requests/holds load mode
//   load_valid_i : load word valid
//   load_data_i  : load word
//   load_ready_o : store accepts a word this cycle
//   load_cnt_o   : words written in the current/last load (saturates at 2**PC_WIDTH)
//   pc_i         : program counter from the execution stage
//   instr_o      : mem[pc_i] while running, otherwise INSTR_NOP
//   run_o        : program valid, execution stage may run
//   rd_addr_i    : readback address          (READBACK_EN only)
//   rd_data_o    : registered readback word  (READBACK_EN only)
// -----------------------------------------------------------------------------
module ppwm_prog_mem
    import ppwm_pkg::*;
#(
    parameter int INSTR_WIDTH = PPWM_INSTR_WIDTH,
    parameter int PC_WIDTH    = PPWM_PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en_i,
    input  logic                   load_valid_i,
    input  logic [INSTR_WIDTH-1:0] load_data_i,
    output logic                   load_ready_o,
    output logic [PC_WIDTH:0]      load_cnt_o,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   run_o
`ifdef PPWM_PROG_MEM_READBACK_EN
    ,
    input  logic [PC_WIDTH-1:0]    rd_addr_i,
    output logic [INSTR_WIDTH-1:0] rd_data_o
`endif
);

    localparam logic [PC_WIDTH:0]      CNT_FULL = {1'b1, {PC_WIDTH{1'b0}}};
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(INSTR_NOP);

    prog_state_e            state;
    prog_state_e            state_next;
    logic [PC_WIDTH-1:0]    wr_ptr;
    logic [PC_WIDTH:0]      load_cnt;
    logic [PC_WIDTH:0]      cnt_after;
    logic                   load_en_q;
    logic                   xfer;
    logic                   enter_load;
    logic [INSTR_WIDTH-1:0] mem_word;

    // Ready comes from registered state only, so there is no valid->ready path.
    assign load_ready_o = (state == StLoad);
    assign run_o        = (state == StRun);
    assign xfer         = load_valid_i & load_ready_o;

    // Count including this cycle's transfer; exit decisions use this value so
    // a transfer coinciding with load_en_i falling is accepted before exiting.
    always_comb begin
        cnt_after = load_cnt;
        if (xfer && (load_cnt != CNT_FULL)) begin
            cnt_after = load_cnt + 1'b1;
        end
    end

    // NOTE: every output of a combinational block gets a default assignment at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            StEmpty: begin
                if (load_en_i) begin
                    state_next = StLoad;
                end
            end
            StLoad: begin
                if (cnt_after == CNT_FULL) begin
                    state_next = StRun;
                end else if (!load_en_i) begin
                    state_next = (cnt_after != '0) ? StRun : StEmpty;
                end
            end
            StRun: begin
                // Only a fresh 0->1 edge reloads; a level held high after an
                // automatic exit from a full load must not re-enter.
                if (load_en_i && !load_en_q) begin
                    state_next = StLoad;
                end
            end
            default: state_next = StEmpty;
        endcase
    end

    // The array is wiped on the same edge that registers StLoad.
    assign enter_load = (state_next == StLoad) && (state != StLoad);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StEmpty;
            wr_ptr    <= '0;
            load_cnt  <= '0;
            load_en_q <= 1'b0;
        end else begin
            state     <= state_next;
            load_en_q <= load_en_i;
            if (enter_load) begin
                wr_ptr   <= '0;
                load_cnt <= '0;
            end else if (xfer) begin
                wr_ptr   <= wr_ptr + 1'b1;   // wraps to 0 after the last word
                load_cnt <= cnt_after;
            end
        end
    end

    assign load_cnt_o = load_cnt;

    ppwm_prog_regfile #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .PC_WIDTH    (PC_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .clr     (enter_load),
        .we      (xfer),
        .waddr   (wr_ptr),
        .wdata   (load_data_i),
        .raddr   (pc_i),
        .rdata   (mem_word)
`ifdef PPWM_PROG_MEM_READBACK_EN
        ,
        .rd_addr (rd_addr_i),
        .rd_data (rd_data_o)
`endif
    );

    assign instr_o = run_o ? mem_word : NOP_WORD;

endmodule : ppwm_prog_mem

// File: tb/tb_ppwm_prog_mem.sv
// -----------------------------------------------------------------------------
// tb_ppwm_prog_mem
// Self-checking bench for ppwm_prog_mem: directed scenarios followed by random
// load/run traffic, all compared against a behavioural model of the store.
// Honours PPWM_PROG_MEM_READBACK_EN when defined.
// -----------------------------------------------------------------------------
module tb_ppwm_prog_mem;

    localparam int IW    = 7;
    localparam int PW    = 4;
    localparam int DEPTH = 16;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en_i;
    logic          load_valid_i;
    logic [IW-1:0] load_data_i;
    logic          load_ready_o;
    logic [PW:0]   load_cnt_o;
    logic [PW-1:0] pc_i;
    logic [IW-1:0] instr_o;
    logic          run_o;
`ifdef PPWM_PROG_MEM_READBACK_EN
    logic [PW-1:0] rd_addr_i;
    logic [IW-1:0] rd_data_o;
`endif

    always #5 clk = ~clk;

    ppwm_prog_mem #(.INSTR_WIDTH(IW), .PC_WIDTH(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en_i    (load_en_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_cnt_o   (load_cnt_o),
        .pc_i         (pc_i),
        .instr_o      (instr_o),
        .run_o        (run_o)
`ifdef PPWM_PROG_MEM_READBACK_EN
        ,
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_mode;
    int m_mem [DEPTH];
    int m_cnt;
    bit m_prev_en;
    int m_rd;

    function automatic void m_wipe();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    endfunction

    function automatic void m_reset();
        m_mode    = M_IDLE;
        m_cnt     = 0;
        m_prev_en = 1'b0;
        m_rd      = 0;
        m_wipe();
    endfunction

    function automatic void m_clock(input bit en, input bit valid, input int data, input int rda);
        m_rd = m_mem[rda];
        case (m_mode)
            M_IDLE: if (en) begin
                m_mode = M_LOAD; m_cnt = 0; m_wipe();
            end
            M_LOAD: begin
                if (valid) begin
                    m_mem[m_cnt % DEPTH] = data;
                    m_cnt++;
                end
                if (m_cnt == DEPTH) m_mode = M_RUN;
                else if (!en) m_mode = (m_cnt > 0) ? M_RUN : M_IDLE;
            end
            default: if (en && !m_prev_en) begin
                m_mode = M_LOAD; m_cnt = 0; m_wipe();
            end
        endcase
        m_prev_en = en;
    endfunction

    task automatic check_outputs(input string tag);
        int pc;
        pc = int'(pc_i);
        check({tag, ".ready"}, 32'(load_ready_o), 32'(m_mode == M_LOAD));
        check({tag, ".run"},   32'(run_o),        32'(m_mode == M_RUN));
        check({tag, ".cnt"},   32'(load_cnt_o),   32'(m_cnt));
        check({tag, ".instr"}, 32'(instr_o),      (m_mode == M_RUN) ? 32'(m_mem[pc]) : 32'd0);
`ifdef PPWM_PROG_MEM_READBACK_EN
        check({tag, ".rd"},    32'(rd_data_o),    32'(m_rd));
`endif
    endtask

    // One clock: drive after the falling edge, check mid-cycle, then advance
    // the model on the rising edge with the same inputs the DUT sampled.
    task automatic step(input bit en, input bit valid, input int data, input int pc, input int rda);
        @(negedge clk);
        load_en_i    = en;
        load_valid_i = valid;
        load_data_i  = IW'(data);
        pc_i         = PW'(pc);
`ifdef PPWM_PROG_MEM_READBACK_EN
        rd_addr_i    = PW'(rda);
`endif
        #1;
        check_outputs("cyc");
        @(posedge clk);
        m_clock(en, valid, data, rda);
    endtask

    // Look at the settled post-edge state with a chosen PC, between edges.
    task automatic peek(input int pc);
        #2;
        pc_i = PW'(pc);
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, ".run"},   32'(run_o),        32'd0);
        check({tag, ".ready"}, 32'(load_ready_o), 32'd0);
        check({tag, ".instr"}, 32'(instr_o),      32'd0);
        check({tag, ".cnt"},   32'(load_cnt_o),   32'd0);
        load_en_i    = 1'b0;
        load_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    bit en_r;

    initial begin
        rst          = 1'b1;
        load_en_i    = 1'b0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        pc_i         = '0;
`ifdef PPWM_PROG_MEM_READBACK_EN
        rd_addr_i    = '0;
`endif
        m_reset();
        #1;
        check("rst.run",   32'(run_o),        32'd0);
        check("rst.ready", 32'(load_ready_o), 32'd0);
        check("rst.instr", 32'(instr_o),      32'd0);
        check("rst.cnt",   32'(load_cnt_o),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full back-to-back load of 0x10..0x1F.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 'h10 + i, i, i);
        peek(5);
        check("full.ready", 32'(load_ready_o), 32'd0);
        check("full.run",   32'(run_o),        32'd1);
        check("full.cnt",   32'(load_cnt_o),   32'd16);
        check("full.instr", 32'(instr_o),      32'h15);
        // Holding load_en_i high must not reload.
        for (int i = 0; i < 3; i++) step(1, 1, 'h55, i, 0);
        peek(15);
        check("hold.run",   32'(run_o),   32'd1);
        check("hold.instr", 32'(instr_o), 32'h1F);

        // Fresh edge clears and enters load; dropping with no words -> empty.
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        peek(5);
        check("reload.run",   32'(run_o),   32'd0);
        check("reload.instr", 32'(instr_o), 32'd0);
        step(0, 0, 0, 5, 5);
        peek(5);
        check("empty.run", 32'(run_o),      32'd0);
        check("empty.cnt", 32'(load_cnt_o), 32'd0);

        // Partial load with gaps, then drop load_en_i.
        step(1, 0, 0, 0, 0);
        step(1, 1, 'h41, 0, 0);
        step(1, 0, 'h33, 0, 0);
        step(1, 1, 'h42, 0, 0);
        step(1, 0, 'h33, 0, 0);
        step(1, 1, 'h43, 0, 0);
        step(0, 0, 0, 0, 0);
        peek(2);
        check("part.run",    32'(run_o),      32'd1);
        check("part.cnt",    32'(load_cnt_o), 32'd3);
        check("part.instr2", 32'(instr_o),    32'h43);
        peek(3);
        check("part.instr3", 32'(instr_o),    32'd0);

        // load_en_i falls together with the second transfer.
        step(1, 0, 0, 0, 0);
        step(1, 1, 'h21, 0, 0);
        step(0, 1, 'h22, 0, 0);
        peek(1);
        check("fall.run",   32'(run_o),      32'd1);
        check("fall.cnt",   32'(load_cnt_o), 32'd2);
        check("fall.instr", 32'(instr_o),    32'h22);

`ifdef PPWM_PROG_MEM_READBACK_EN
        step(1, 0, 0, 0, 0);
        step(1, 1, 'h7F, 0, 0);
        step(0, 0, 0, 0, 0);
        peek(0);
        check("rb.data", 32'(rd_data_o), 32'h7F);
`endif

        // Reset in the middle of a load.
        step(1, 0, 0, 0, 0);
        step(1, 1, 'h66, 0, 0);
        step(1, 1, 'h67, 0, 0);
        async_reset("midrst");
        step(0, 0, 0, 0, 0);

        // Random traffic.
        en_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 11) == 0) en_r = ~en_r;
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rndrst");
                en_r = 1'b0;
            end
            step(en_r, $urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ppwm_prog_mem
